alu_nibble_sequencer: RTL and testbench
=======================================

Name: alu_nibble_sequencer

Overview:
Controller for the nibble-serial 8-bit ALU block. It accepts one operation request, then sequences the ALU bus-writer selects, operand latches, op2 mux, core controls and carry/parity chaining across the low and high nibble passes. It captures the resulting flags and presents the result on the ALU external bus. It sits between the instruction decode/timing logic and the ALU datapath.

Parameters:
None (fixed 8-bit ALU, two 4-bit passes).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP; captured on accept
cf_in  in  1  current carry flag, captured on accept (ADC/SBC)
busy  out  1  high from the cycle after accept through DONE
done  out  1  one-cycle pulse in DONE
drive_op  out  2  01: host drives operand A on db; 10: host drives operand B; 00: none
bus_sel  out  3  ALU internal bus writer: 0 HIGHZ, 1 OP1, 2 OP2, 3 RES, 4 SHIFT, 5 BS
alu_op1_sel_bus  out  1  load OP1 latch from internal bus
alu_op2_sel_bus  out  1  load OP2 latch from internal bus
alu_sel_op2_neg  out  1  complemented OP2 (SUB/SBC/CP)
alu_sel_op2_high  out  1  high OP2 nibble select
alu_op_low  out  1  low-nibble compute/store
alu_core_cf_in  out  1  core carry in
alu_core_rsv  out  3  {R,S,V}: arith 000, AND 100, XOR 001, OR 110
alu_parity_in  out  1  parity chained into high pass
alu_oe  out  1  ALU drives external db
alu_core_cf_out  in  1  core carry out
alu_vf_out  in  1  overflow out
alu_parity_out  in  1  accumulated parity (1 = even)
alu_zero  in  1  current nibble result zero
alu_sf_out  in  1  result bit 7
flags  out  6  {S,Z,H,PV,N,C}, registered

Behaviour:
- States: IDLE -> LOAD1 -> LOAD2 -> LOW -> HIGH -> DONE -> IDLE. One cycle each. Start is accepted in IDLE only, so result is on db in the 5th cycle after accept.
- Reset: state IDLE; all outputs 0, including flags and bus_sel=HIGHZ. Reset in any state aborts the operation. Next cycle is IDLE with outputs 0 and flags cleared.
- IDLE: all controls 0. start=1 captures op and cf_in, then goes to LOAD1.
- LOAD1: drive_op=01, bus_sel=SHIFT, alu_op1_sel_bus=1.
- LOAD2: drive_op=10, bus_sel=SHIFT, alu_op2_sel_bus=1.
- LOW: alu_op_low=1, sel_op2_high=0, parity_in=0, rsv per op, neg per op.
  - Carry in: ADD 0, ADC cf_in, SUB/CP 1, SBC ~cf_in; logic ops 0.
  - At the clock edge, register hc=core_cf_out, pl=parity_out, zl=alu_zero.
- HIGH: sel_op2_high=1, core_cf_in=hc, parity_in=pl, op_low=0, rsv/neg held.
  - At the clock edge, update flags:
    - S=sf_out; Z=zl & alu_zero.
    - N=1 for SUB/SBC/CP, else 0.
    - Arithmetic: C = core_cf_out (ADD/ADC) or ~core_cf_out (SUB/SBC/CP); H = hc or ~hc likewise; PV = vf_out.
    - Logic: C=0; H=1 for AND, 0 for OR/XOR; PV = parity_out.
- DONE: done=1, bus_sel=RES, alu_oe=1. Exception for CP: bus_sel=HIGHZ, alu_oe=0, since only flags update.
- Flags hold from the HIGH edge until the next operation's HIGH edge.
- start while busy is ignored; start in the DONE cycle is ignored. A held start re-issues from IDLE.
- drive_op and alu_oe are never both nonzero in the same cycle.

Test Plan:
- ADD A=8C, B=6D -> db=F9 in DONE; flags S1 Z0 H1 PV0 N0 C0; done pulses once; busy high for 5 cycles.
- ADC A=FF, B=00, cf_in=1 -> db=00; S0 Z1 H1 PV0 N0 C1.
- SUB A=10, B=01 -> db=0F; S0 Z0 H1 PV0 N1 C0. CP A=42, B=42 -> alu_oe stays 0 throughout; Z1 N1 C0 H0.
- AND A=F0, B=3C -> db=30; H1 C0 PV1 (even parity), rsv=100. XOR A=FF, B=FF -> db=00; Z1 PV1 H0.
- Reset asserted in LOW -> next cycle IDLE; busy=0; all controls 0; flags=0; no done pulse. A new start then completes normally.
- start pulsed again during LOAD2 and during DONE -> ignored; exactly one done per accepted start. Start held high -> back-to-back ops 6 cycles apart.

Source files
------------

// File: rtl/alu_nibble_sequencer_if.sv
`default_nettype none
// =============================================================================
// alu_nibble_sequencer_if : request, ALU control and ALU status bundle
// Revision: 1.0
// =============================================================================
interface alu_nibble_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic       cf_in;
  logic       busy;
  logic       done;
  logic [1:0] drive_op;
  logic [2:0] bus_sel;
  logic       alu_op1_sel_bus;
  logic       alu_op2_sel_bus;
  logic       alu_sel_op2_neg;
  logic       alu_sel_op2_high;
  logic       alu_op_low;
  logic       alu_core_cf_in;
  logic [2:0] alu_core_rsv;
  logic       alu_parity_in;
  logic       alu_oe;
  logic       alu_core_cf_out;
  logic       alu_vf_out;
  logic       alu_parity_out;
  logic       alu_zero;
  logic       alu_sf_out;
  logic [5:0] flags;

  modport slave (
    input  start, op, cf_in,
    input  alu_core_cf_out, alu_vf_out, alu_parity_out, alu_zero, alu_sf_out,
    output busy, done, drive_op, bus_sel, alu_op1_sel_bus, alu_op2_sel_bus,
    output alu_sel_op2_neg, alu_sel_op2_high, alu_op_low, alu_core_cf_in,
    output alu_core_rsv, alu_parity_in, alu_oe, flags
  );

  modport master (
    output start, op, cf_in,
    output alu_core_cf_out, alu_vf_out, alu_parity_out, alu_zero, alu_sf_out,
    input  busy, done, drive_op, bus_sel, alu_op1_sel_bus, alu_op2_sel_bus,
    input  alu_sel_op2_neg, alu_sel_op2_high, alu_op_low, alu_core_cf_in,
    input  alu_core_rsv, alu_parity_in, alu_oe, flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// =============================================================================
// alu_nibble_sequencer : sequences the nibble-serial 8-bit ALU through two passes
// Revision: 1.0
// =============================================================================
module alu_nibble_sequencer (
  input  logic                   clk,
  input  logic                   reset,
  alu_nibble_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_ADC = 3'd1;
  localparam logic [2:0] c_OP_SUB = 3'd2;
  localparam logic [2:0] c_OP_SBC = 3'd3;
  localparam logic [2:0] c_OP_AND = 3'd4;
  localparam logic [2:0] c_OP_XOR = 3'd5;
  localparam logic [2:0] c_OP_OR  = 3'd6;
  localparam logic [2:0] c_OP_CP  = 3'd7;

  localparam logic [2:0] c_BUS_HIGHZ = 3'd0;
  localparam logic [2:0] c_BUS_RES   = 3'd3;
  localparam logic [2:0] c_BUS_SHIFT = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       cf_q, cf_d;
  logic       hc_q, hc_d;
  logic       pl_q, pl_d;
  logic       zl_q, zl_d;
  logic [5:0] flags_q, flags_d;

  logic       w_is_sub;
  logic       w_is_logic;
  logic [2:0] w_rsv;
  logic       w_cin;
  logic [5:0] w_flags;

  always_comb begin
    w_is_sub   = (op_q == c_OP_SUB) || (op_q == c_OP_SBC) || (op_q == c_OP_CP);
    w_is_logic = (op_q == c_OP_AND) || (op_q == c_OP_XOR) || (op_q == c_OP_OR);

    case (op_q)
      c_OP_AND: w_rsv = 3'b100;
      c_OP_XOR: w_rsv = 3'b001;
      c_OP_OR:  w_rsv = 3'b110;
      default:  w_rsv = 3'b000;
    endcase

    // Subtraction runs as A + ~B + 1, so borrow-in becomes inverted carry-in
    case (op_q)
      c_OP_ADC: w_cin = cf_q;
      c_OP_SUB: w_cin = 1'b1;
      c_OP_CP:  w_cin = 1'b1;
      c_OP_SBC: w_cin = ~cf_q;
      default:  w_cin = 1'b0;
    endcase

    // {S,Z,H,PV,N,C}; subtract flags report borrow, hence the inversions
    if (w_is_logic) begin
      w_flags = {bus.alu_sf_out, zl_q & bus.alu_zero, op_q == c_OP_AND,
                 bus.alu_parity_out, 1'b0, 1'b0};
    end else begin
      w_flags = {bus.alu_sf_out, zl_q & bus.alu_zero, hc_q ^ w_is_sub,
                 bus.alu_vf_out, w_is_sub, bus.alu_core_cf_out ^ w_is_sub};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      cf_q    <= 1'b0;
      hc_q    <= 1'b0;
      pl_q    <= 1'b0;
      zl_q    <= 1'b0;
      flags_q <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cf_q    <= cf_d;
      hc_q    <= hc_d;
      pl_q    <= pl_d;
      zl_q    <= zl_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cf_d    = cf_q;
    hc_d    = hc_q;
    pl_d    = pl_q;
    zl_d    = zl_q;
    flags_d = flags_q;

    bus.busy             = (state_q != S_IDLE);
    bus.done             = 1'b0;
    bus.drive_op         = 2'b00;
    bus.bus_sel          = c_BUS_HIGHZ;
    bus.alu_op1_sel_bus  = 1'b0;
    bus.alu_op2_sel_bus  = 1'b0;
    bus.alu_sel_op2_neg  = 1'b0;
    bus.alu_sel_op2_high = 1'b0;
    bus.alu_op_low       = 1'b0;
    bus.alu_core_cf_in   = 1'b0;
    bus.alu_core_rsv     = 3'b000;
    bus.alu_parity_in    = 1'b0;
    bus.alu_oe           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          cf_d    = bus.cf_in;
          state_d = S_LOAD1;
        end
      end
      S_LOAD1: begin
        bus.drive_op        = 2'b01;
        bus.bus_sel         = c_BUS_SHIFT;
        bus.alu_op1_sel_bus = 1'b1;
        state_d             = S_LOAD2;
      end
      S_LOAD2: begin
        bus.drive_op        = 2'b10;
        bus.bus_sel         = c_BUS_SHIFT;
        bus.alu_op2_sel_bus = 1'b1;
        state_d             = S_LOW;
      end
      S_LOW: begin
        bus.alu_op_low      = 1'b1;
        bus.alu_sel_op2_neg = w_is_sub;
        bus.alu_core_rsv    = w_rsv;
        bus.alu_core_cf_in  = w_cin;
        hc_d                = bus.alu_core_cf_out;
        pl_d                = bus.alu_parity_out;
        zl_d                = bus.alu_zero;
        state_d             = S_HIGH;
      end
      S_HIGH: begin
        bus.alu_sel_op2_high = 1'b1;
        bus.alu_sel_op2_neg  = w_is_sub;
        bus.alu_core_rsv     = w_rsv;
        bus.alu_core_cf_in   = hc_q;
        bus.alu_parity_in    = pl_q;
        flags_d              = w_flags;
        state_d              = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        // CP only updates flags; the result never reaches the external bus
        if (op_q != c_OP_CP) begin
          bus.bus_sel = c_BUS_RES;
          bus.alu_oe  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// =============================================================================
// tb_alu_nibble_sequencer : drives the sequencer with a nibble ALU stub and
// compares results and flags against an 8-bit arithmetic reference.
// Revision: 1.0
// =============================================================================
module tb_alu_nibble_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_nibble_sequencer_if bif ();
  alu_nibble_sequencer dut (.clk(clk), .reset(reset), .bus(bif));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;

  // ---------------- nibble ALU datapath stub ----------------
  logic [7:0] a_v, b_v, op1_q, op2_q;
  logic [3:0] res_lo, res_hi, a_n, b_n, r_n;
  logic [4:0] sum;
  logic       m_cf, m_vf, m_par;
  logic [7:0] db;

  always_comb begin
    a_n = bif.alu_sel_op2_high ? op1_q[7:4] : op1_q[3:0];
    b_n = bif.alu_sel_op2_high ? op2_q[7:4] : op2_q[3:0];
    if (bif.alu_sel_op2_neg) b_n = ~b_n;
    sum = {1'b0, a_n} + {1'b0, b_n} + {4'd0, bif.alu_core_cf_in};
    case (bif.alu_core_rsv)
      3'b100:  r_n = a_n & b_n;
      3'b110:  r_n = a_n | b_n;
      3'b001:  r_n = a_n ^ b_n;
      default: r_n = sum[3:0];
    endcase
    m_cf  = (bif.alu_core_rsv == 3'b000) ? sum[4] : 1'b0;
    m_vf  = (a_n[3] == b_n[3]) && (r_n[3] != a_n[3]);
    m_par = bif.alu_op_low ? ~^r_n : (bif.alu_parity_in ^ (^r_n));
  end

  assign bif.alu_core_cf_out = m_cf;
  assign bif.alu_vf_out      = m_vf;
  assign bif.alu_parity_out  = m_par;
  assign bif.alu_zero        = (r_n == 4'd0);
  assign bif.alu_sf_out      = r_n[3];
  assign db                  = {res_hi, res_lo};

  always_ff @(posedge clk) begin
    if (bif.alu_op1_sel_bus && bif.drive_op == 2'b01 && bif.bus_sel == 3'd4) op1_q <= a_v;
    if (bif.alu_op2_sel_bus && bif.drive_op == 2'b10 && bif.bus_sel == 3'd4) op2_q <= b_v;
    if (bif.alu_op_low)       res_lo <= r_n;
    if (bif.alu_sel_op2_high) res_hi <= r_n;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bif.done === 1'b1) done_cnt++;
    chk("drive_oe_exclusive", {31'd0, (bif.drive_op != 2'b00) && (bif.alu_oe === 1'b1)}, 32'd0);
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {14'd0, bif.busy, bif.done, bif.drive_op, bif.bus_sel, bif.alu_op1_sel_bus,
            bif.alu_op2_sel_bus, bif.alu_sel_op2_neg, bif.alu_sel_op2_high, bif.alu_op_low,
            bif.alu_core_cf_in, bif.alu_core_rsv, bif.alu_parity_in, bif.alu_oe};
  endfunction

  // Reference: plain 8-bit arithmetic; flags {S,Z,H,PV,N,C}
  task automatic ref_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, output logic [7:0] r, output logic [5:0] f);
    int ai, bi, ci, s, h;
    logic cy, hf, v, n;
    ai = int'(a);
    bi = int'(b);
    ci = (op == 3'd1 || op == 3'd3) ? int'(c) : 0;
    cy = 1'b0; hf = 1'b0; v = 1'b0; n = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        s  = ai + bi + ci;
        h  = (ai % 16) + (bi % 16) + ci;
        r  = s[7:0];
        cy = (s > 255);
        hf = (h > 15);
        v  = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd2, 3'd3, 3'd7: begin
        s  = ai - bi - ci;
        h  = (ai % 16) - (bi % 16) - ci;
        r  = s[7:0];
        cy = (s < 0);
        hf = (h < 0);
        v  = (a[7] != b[7]) && (r[7] != a[7]);
        n  = 1'b1;
      end
      default: begin
        r  = (op == 3'd4) ? (a & b) : (op == 3'd5) ? (a ^ b) : (a | b);
        hf = (op == 3'd4);
        v  = ~^r;
      end
    endcase
    f = {r[7], r == 8'd0, hf, v, n, cy};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit poke_load2, input bit poke_done);
    logic [7:0] r;
    logic [5:0] f;
    logic [2:0] rsv;
    logic       neg, cin;
    int         d0;
    ref_calc(op, a, b, c, r, f);
    rsv = (op == 3'd4) ? 3'b100 : (op == 3'd5) ? 3'b001 : (op == 3'd6) ? 3'b110 : 3'b000;
    neg = (op == 3'd2 || op == 3'd3 || op == 3'd7);
    cin = (op == 3'd1) ? c : (op == 3'd3) ? ~c : neg;
    d0  = done_cnt;
    bif.start = 1'b1; bif.op = op; bif.cf_in = c; a_v = a; b_v = b;
    step();
    bif.start = 1'b0;
    chk("load1_busy", bif.busy, 1);
    chk("load1_drive_op", bif.drive_op, 2'b01);
    chk("load1_bus_sel", bif.bus_sel, 3'd4);
    chk("load1_op1_sel", bif.alu_op1_sel_bus, 1);
    step();
    chk("load2_drive_op", bif.drive_op, 2'b10);
    chk("load2_op2_sel", bif.alu_op2_sel_bus, 1);
    if (poke_load2) bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    chk("low_ctrl", {bif.alu_op_low, bif.alu_sel_op2_high, bif.alu_parity_in}, 3'b100);
    chk("low_rsv", bif.alu_core_rsv, rsv);
    chk("low_neg", bif.alu_sel_op2_neg, neg);
    chk("low_cf_in", bif.alu_core_cf_in, cin);
    step();
    chk("high_ctrl", {bif.alu_op_low, bif.alu_sel_op2_high}, 2'b01);
    chk("high_rsv_neg", {bif.alu_core_rsv, bif.alu_sel_op2_neg}, {rsv, neg});
    step();
    chk("done_pulse", {bif.done, bif.busy}, 2'b11);
    chk("done_flags", bif.flags, f);
    chk("done_oe", bif.alu_oe, (op != 3'd7));
    chk("done_bus_sel", bif.bus_sel, (op == 3'd7) ? 3'd0 : 3'd3);
    if (op != 3'd7) chk("done_db", db, r);
    if (poke_done) bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    chk("idle_ctrl", ctrl_vec(), 0);
    chk("idle_flags_hold", bif.flags, f);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int t1, t2;
    bit got;
    reset = 1'b1; bif.start = 1'b0; bif.op = 3'd0; bif.cf_in = 1'b0; a_v = 8'd0; b_v = 8'd0;
    step(); step();
    chk("reset_ctrl", ctrl_vec(), 0);
    chk("reset_flags", bif.flags, 0);
    reset = 1'b0;
    step();
    chk("idle_stays", bif.busy, 0);

    // directed cases from the operation list
    run_op(3'd0, 8'h8C, 8'h6D, 1'b0, 0, 0);
    chk("add_flags_const", bif.flags, 6'b101000);
    run_op(3'd1, 8'hFF, 8'h00, 1'b1, 0, 0);
    chk("adc_flags_const", bif.flags, 6'b011001);
    run_op(3'd2, 8'h10, 8'h01, 1'b0, 0, 0);
    chk("sub_flags_const", bif.flags, 6'b001010);
    run_op(3'd7, 8'h42, 8'h42, 1'b0, 0, 0);
    run_op(3'd4, 8'hF0, 8'h3C, 1'b0, 0, 0);
    chk("and_flags_const", bif.flags, 6'b001100);
    run_op(3'd5, 8'hFF, 8'hFF, 1'b0, 0, 0);
    run_op(3'd6, 8'h81, 8'h02, 1'b0, 0, 0);
    run_op(3'd3, 8'h00, 8'h00, 1'b1, 0, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
    end

    // start pulses while busy and in DONE must be ignored
    run_op(3'd0, 8'h12, 8'h34, 1'b0, 1, 1);
    step();
    chk("no_reaccept", bif.busy, 0);

    // reset in LOW aborts
    run_op(3'd2, 8'h00, 8'h01, 1'b0, 0, 0);
    t1 = done_cnt;
    bif.start = 1'b1; bif.op = 3'd0; a_v = 8'h01; b_v = 8'h02;
    step();
    bif.start = 1'b0;
    step(); step();
    chk("in_low_before_reset", bif.alu_op_low, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ctrl", ctrl_vec(), 0);
    chk("abort_flags", bif.flags, 0);
    step(); step(); step();
    chk("abort_no_done", done_cnt - t1, 0);
    run_op(3'd0, 8'h0F, 8'h01, 1'b0, 0, 0);

    // held start: back-to-back operations six cycles apart
    bif.start = 1'b1; bif.op = 3'd0; a_v = 8'h11; b_v = 8'h22;
    got = 0; t1 = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (bif.done === 1'b1) begin got = 1; t1 = cyc; end
    end
    chk("held_done1_seen", got, 1);
    got = 0; t2 = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (bif.done === 1'b1) begin got = 1; t2 = cyc; end
    end
    chk("held_done2_seen", got, 1);
    chk("held_spacing", t2 - t1, 6);
    chk("held_db", db, 8'h33);
    bif.start = 1'b0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (bif.busy === 1'b0) got = 1;
    end
    chk("held_returns_idle", got, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
